// File: rtl/snake_score_ssd_if.sv
// Score display bus between the game core (master) and the seven-segment driver (slave).
interface snake_score_ssd_if #(
    parameter int LEN_W = 8
);
    logic [LEN_W-1:0] Length;
    logic             Blink;
    logic             Busy;
    logic [7:0]       An;
    logic [7:0]       Seg;

    modport master (output Length, output Blink, input Busy, input An, input Seg);
    modport slave  (input Length, input Blink, output Busy, output An, output Seg);
endinterface

// File: rtl/snake_score_ssd.sv
// Snake score seven-segment driver: sequential double-dabble BCD conversion plus multiplexed display.
// Optional game-over blinking is enabled by defining SNAKE_SSD_BLINK_EN.
module snake_score_ssd #(
    parameter int LEN_W   = 8,
    parameter int SCAN_W  = 18,
    parameter int BLINK_W = 26
) (
    input logic              clk,
    input logic              rst,
    snake_score_ssd_if.slave bus
);

    localparam int SR_W  = LEN_W + 16;
    localparam int CNT_W = $clog2(LEN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LOAD} state_t;

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  shown_q, shown_d;
    logic [15:0]       digits_q, digits_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SCAN_W-1:0] scan_q;
    logic [7:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [15:0]       bcdAdj;
    logic [1:0]        sel;
    logic [3:0]        curDigit;
    logic              blank;

    function automatic logic [7:0] encode(input logic [3:0] d);
        case (d)
            4'd0:    encode = 8'b00000011;
            4'd1:    encode = 8'b10011111;
            4'd2:    encode = 8'b00100101;
            4'd3:    encode = 8'b00001101;
            4'd4:    encode = 8'b10011001;
            4'd5:    encode = 8'b01001001;
            4'd6:    encode = 8'b01000001;
            4'd7:    encode = 8'b00011111;
            4'd8:    encode = 8'b00000001;
            4'd9:    encode = 8'b00001001;
            default: encode = 8'hFF;
        endcase
    endfunction

    // Add-3 correction on each BCD nibble before the shift.
    always_comb begin
        bcdAdj = '0;
        for (int k = 0; k < 4; k++) begin
            bcdAdj[4*k +: 4] = (sr_q[LEN_W+4*k +: 4] >= 4'd5) ?
                               sr_q[LEN_W+4*k +: 4] + 4'd3 : sr_q[LEN_W+4*k +: 4];
        end
    end

    always_comb begin
        state_d  = state_q;
        shown_d  = shown_q;
        digits_d = digits_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.Length != shown_q) begin
                    sr_d    = {16'd0, bus.Length};
                    shown_d = bus.Length;
                    cnt_d   = CNT_W'(LEN_W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {bcdAdj[14:0], sr_q[LEN_W-1:0], 1'b0};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                digits_d = sr_q[SR_W-1 -: 16];
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SNAKE_SSD_BLINK_EN
    logic [BLINK_W-1:0] blink_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_q <= '0;
        end else begin
            blink_q <= blink_q + BLINK_W'(1);
        end
    end
`else
    logic unusedBlink;
    assign unusedBlink = bus.Blink & (BLINK_W > 0);
`endif

    // A digit is blank only when it and every digit above it are zero.
    always_comb begin
        sel      = scan_q[SCAN_W-1 -: 2];
        curDigit = digits_q[4*sel +: 4];
        case (sel)
            2'd1:    blank = (digits_q[15:4] == 12'd0);
            2'd2:    blank = (digits_q[15:8] == 8'd0);
            2'd3:    blank = (digits_q[15:12] == 4'd0);
            default: blank = 1'b0;
        endcase
        an_d  = blank ? 8'hFF : ~(8'h01 << sel);
        seg_d = blank ? 8'hFF : encode(curDigit);
`ifdef SNAKE_SSD_BLINK_EN
        if (bus.Blink && blink_q[BLINK_W-1]) begin
            an_d  = 8'hFF;
            seg_d = 8'hFF;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shown_q  <= '0;
            digits_q <= '0;
            sr_q     <= '0;
            cnt_q    <= '0;
            scan_q   <= '0;
            an_q     <= 8'hFF;
            seg_q    <= 8'hFF;
        end else begin
            state_q  <= state_d;
            shown_q  <= shown_d;
            digits_q <= digits_d;
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            scan_q   <= scan_q + SCAN_W'(1);
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    assign bus.Busy = (state_q != IDLE);
    assign bus.An   = an_q;
    assign bus.Seg  = seg_q;

endmodule

// File: tb/tb_snake_score_ssd.sv
// Directed self-checking bench for snake_score_ssd (LEN_W=8, SCAN_W=4, BLINK_W=5).
module tb_snake_score_ssd;

    localparam int LEN_W   = 8;
    localparam int SCAN_W  = 4;
    localparam int BLINK_W = 5;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad = 0;
    int   edgeCnt;

    snake_score_ssd_if #(.LEN_W(LEN_W)) bus ();

    snake_score_ssd #(.LEN_W(LEN_W), .SCAN_W(SCAN_W), .BLINK_W(BLINK_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; the output seen after edge e was selected by scan value e-1.
    always @(posedge clk or posedge rst) begin
        if (rst) edgeCnt <= 0;
        else     edgeCnt <= edgeCnt + 1;
    end

    function automatic logic [7:0] segOf(input int d);
        case (d)
            0: return 8'h03;  1: return 8'h9F;  2: return 8'h25;  3: return 8'h0D;
            4: return 8'h99;  5: return 8'h49;  6: return 8'h41;  7: return 8'h1F;
            8: return 8'h01;  9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic int selOf(input int e);
        return ((e - 1) % 16) / 4;
    endfunction

    function automatic logic [7:0] anOf(input int s);
        case (s)
            0: return 8'hFE;  1: return 8'hFD;  2: return 8'hFB;
            default: return 8'hF7;
        endcase
    endfunction

    task automatic applyStimulus(input int len, input logic blk);
        @(negedge clk);
        bus.Length = LEN_W'(len);
        bus.Blink  = blk;
    endtask

    task automatic waitIdle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!bus.Busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic captureFrame(output logic [3:0][7:0] segs, output logic [3:0] seen, output int ffCnt);
        segs  = '1;
        seen  = '0;
        ffCnt = 0;
        repeat (16) begin
            @(negedge clk);
            case (bus.An)
                8'hFE: begin seen[0] = 1'b1; segs[0] = bus.Seg; end
                8'hFD: begin seen[1] = 1'b1; segs[1] = bus.Seg; end
                8'hFB: begin seen[2] = 1'b1; segs[2] = bus.Seg; end
                8'hF7: begin seen[3] = 1'b1; segs[3] = bus.Seg; end
                8'hFF: ffCnt++;
                default: ;
            endcase
        end
    endtask

    task automatic test_reset();
        int errs;
        bus.Length = '0;
        bus.Blink  = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (bus.An !== 8'hFF) begin bad++; $display("[TB] FAIL reset_an: got %h want ff", bus.An); end
        total++; if (bus.Seg !== 8'hFF) begin bad++; $display("[TB] FAIL reset_seg: got %h want ff", bus.Seg); end
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", bus.Busy); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.An !== 8'hFE) begin bad++; $display("[TB] FAIL release_an: got %h want fe", bus.An); end
        total++; if (bus.Seg !== 8'h03) begin bad++; $display("[TB] FAIL release_seg: got %h want 03", bus.Seg); end
        errs = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.Busy !== 1'b0 || bus.An[3:1] !== 3'b111) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("[TB] FAIL zero_idle: got %0d bad cycles want 0", errs); end
    endtask

    task automatic test_two_digit();
        int busyCnt;
        logic [3:0][7:0] segs;
        logic [3:0] seen;
        int ffCnt;
        applyStimulus(37, 1'b0);
        @(negedge clk);
        total++; if (bus.Busy !== 1'b1) begin bad++; $display("[TB] FAIL busy_rise: got %b want 1", bus.Busy); end
        busyCnt = 1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.Busy === 1'b1) busyCnt++;
            else break;
        end
        total++; if (busyCnt != 9) begin bad++; $display("[TB] FAIL busy_len37: got %0d want 9", busyCnt); end
        captureFrame(segs, seen, ffCnt);
        total++; if (segs[0] !== 8'h1F) begin bad++; $display("[TB] FAIL d0_37: got %h want 1f", segs[0]); end
        total++; if (segs[1] !== 8'h0D) begin bad++; $display("[TB] FAIL d1_37: got %h want 0d", segs[1]); end
        total++; if (seen[3:2] !== 2'b00) begin bad++; $display("[TB] FAIL blank_37: got %b want 00", seen[3:2]); end
        total++; if (ffCnt != 8) begin bad++; $display("[TB] FAIL ffslots_37: got %0d want 8", ffCnt); end
    endtask

    task automatic test_full_scale();
        bit ok;
        logic [3:0][7:0] segs;
        logic [3:0] seen;
        int ffCnt;
        applyStimulus(255, 1'b0);
        waitIdle(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL idle_255: got busy want idle"); end
        captureFrame(segs, seen, ffCnt);
        total++; if (segs[2] !== 8'h25) begin bad++; $display("[TB] FAIL d2_255: got %h want 25", segs[2]); end
        total++; if (segs[1] !== 8'h49) begin bad++; $display("[TB] FAIL d1_255: got %h want 49", segs[1]); end
        total++; if (segs[0] !== 8'h49) begin bad++; $display("[TB] FAIL d0_255: got %h want 49", segs[0]); end
        total++; if (seen[3] !== 1'b0 || ffCnt != 4) begin bad++; $display("[TB] FAIL blank_255: got seen3=%b ff=%0d want 0,4", seen[3], ffCnt); end
    endtask

    task automatic test_change_during_conversion();
        logic expBusy;
        int seen12;
        logic [3:0][7:0] segs;
        logic [3:0] seen;
        int ffCnt;
        applyStimulus(12, 1'b0);
        seen12 = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (i == 2) bus.Length = LEN_W'(200);
            expBusy = (i <= 8) || (i >= 10 && i <= 18);
            total++;
            if (bus.Busy !== expBusy) begin bad++; $display("[TB] FAIL busy_seq[%0d]: got %b want %b", i, bus.Busy, expBusy); end
            if (i >= 10 && i <= 19) begin
                if (bus.An === 8'hFE) begin
                    seen12++;
                    total++; if (bus.Seg !== 8'h25) begin bad++; $display("[TB] FAIL mid12_d0[%0d]: got %h want 25", i, bus.Seg); end
                end else if (bus.An === 8'hFD) begin
                    seen12++;
                    total++; if (bus.Seg !== 8'h9F) begin bad++; $display("[TB] FAIL mid12_d1[%0d]: got %h want 9f", i, bus.Seg); end
                end else begin
                    total++; if (bus.An !== 8'hFF) begin bad++; $display("[TB] FAIL mid12_an[%0d]: got %h want ff", i, bus.An); end
                end
            end
        end
        total++; if (seen12 == 0) begin bad++; $display("[TB] FAIL show12: got 0 digit slots want >0"); end
        captureFrame(segs, seen, ffCnt);
        total++; if (segs[2] !== 8'h25) begin bad++; $display("[TB] FAIL d2_200: got %h want 25", segs[2]); end
        total++; if (segs[1] !== 8'h03) begin bad++; $display("[TB] FAIL d1_200: got %h want 03", segs[1]); end
        total++; if (segs[0] !== 8'h03) begin bad++; $display("[TB] FAIL d0_200: got %h want 03", segs[0]); end
        total++; if (seen[3] !== 1'b0) begin bad++; $display("[TB] FAIL blank_200: got %b want 0", seen[3]); end
    endtask

    task automatic test_scan_zero();
        bit ok;
        int s;
        logic [7:0] expAn, expSeg;
        applyStimulus(100, 1'b0);
        waitIdle(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL idle_100: got busy want idle"); end
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            s = selOf(edgeCnt);
            case (s)
                0: begin expAn = 8'hFE; expSeg = 8'h03; end
                1: begin expAn = 8'hFD; expSeg = 8'h03; end
                2: begin expAn = 8'hFB; expSeg = 8'h9F; end
                default: begin expAn = 8'hFF; expSeg = 8'hFF; end
            endcase
            total++; if (bus.An !== expAn) begin bad++; $display("[TB] FAIL scan_an[%0d]: got %h want %h", i, bus.An, expAn); end
            total++; if (bus.Seg !== expSeg) begin bad++; $display("[TB] FAIL scan_seg[%0d]: got %h want %h", i, bus.Seg, expSeg); end
        end
    endtask

    task automatic test_blink();
        int s, ffCnt, expFf;
        logic blinkOn;
        logic [7:0] expAn;
        applyStimulus(100, 1'b1);
        ffCnt = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            s = selOf(edgeCnt);
`ifdef SNAKE_SSD_BLINK_EN
            blinkOn = (((edgeCnt - 1) % 32) >= 16);
`else
            blinkOn = 1'b0;
`endif
            expAn = (blinkOn || s == 3) ? 8'hFF : anOf(s);
            if (bus.An === 8'hFF) ffCnt++;
            total++; if (bus.An !== expAn) begin bad++; $display("[TB] FAIL blink_an[%0d]: got %h want %h", i, bus.An, expAn); end
        end
`ifdef SNAKE_SSD_BLINK_EN
        expFf = 20;
`else
        expFf = 8;
`endif
        total++; if (ffCnt != expFf) begin bad++; $display("[TB] FAIL blink_ffcount: got %0d want %0d", ffCnt, expFf); end
        bus.Blink = 1'b0;
    endtask

    task automatic test_reset_mid_conversion();
        bit ok;
        logic [3:0][7:0] segs;
        logic [3:0] seen;
        int ffCnt;
        applyStimulus(55, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        total++; if (bus.Busy !== 1'b0) begin bad++; $display("[TB] FAIL async_busy: got %b want 0", bus.Busy); end
        total++; if (bus.An !== 8'hFF) begin bad++; $display("[TB] FAIL async_an: got %h want ff", bus.An); end
        total++; if (bus.Seg !== 8'hFF) begin bad++; $display("[TB] FAIL async_seg: got %h want ff", bus.Seg); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.An !== 8'hFE || bus.Seg !== 8'h03) begin bad++; $display("[TB] FAIL rerel_disp: got %h/%h want fe/03", bus.An, bus.Seg); end
        total++; if (bus.Busy !== 1'b1) begin bad++; $display("[TB] FAIL rerel_busy: got %b want 1", bus.Busy); end
        waitIdle(ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL idle_55: got busy want idle"); end
        captureFrame(segs, seen, ffCnt);
        total++; if (segs[1] !== 8'h49 || segs[0] !== 8'h49) begin bad++; $display("[TB] FAIL disp_55: got %h%h want 4949", segs[1], segs[0]); end
        total++; if (seen[3:2] !== 2'b00) begin bad++; $display("[TB] FAIL blank_55: got %b want 00", seen[3:2]); end
    endtask

    initial begin
        test_reset();
        test_two_digit();
        test_full_scale();
        test_change_during_conversion();
        test_scan_zero();
        test_blink();
        test_reset_mid_conversion();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
